mux_2to1_arb: RTL and testbench

Round-robin arbiter that shares the 2:1 select datapath between two valid/ready requesters, a and b. It drives the select `s` (0 = a, 1 = b), applies a per-grant burst limit so neither side starves, and registers the muxed result into a one-entry output buffer with a valid/ready handshake. It sits in front of any single-consumer sink that two producers must share.

---
 rtl/mux_2to1_arb.sv | 127 ++++++++++++
 tb/tb_mux_2to1_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2to1_arb.sv
// Round-robin two-requester arbiter driving a 2:1 select into a one-entry valid/ready output buffer.
// Optional `ARB_STATS_EN adds saturating per-side transfer counters a_cnt/b_cnt.
module mux_2to1_arb #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             s
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      a_cnt,
    output logic [15:0]      b_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL_A = 2'd1,
        SEL_B = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state;
    state_t     next_state;
    logic       last;
    logic [7:0] burst_cnt;
    logic       space;
    logic       xfer_a;
    logic       xfer_b;
    logic       xfer;
    logic       entering;

    // Readies only depend on the grant and on whether the buffer can take a word this cycle.
    always_comb begin
        space   = !y_valid || y_ready;
        a_ready = (state == SEL_A) && space;
        b_ready = (state == SEL_B) && space;
        xfer_a  = a_valid && a_ready;
        xfer_b  = b_valid && b_ready;
        xfer    = xfer_a || xfer_b;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (a_valid && b_valid)
                    next_state = last ? SEL_A : SEL_B;
                else if (a_valid)
                    next_state = SEL_A;
                else if (b_valid)
                    next_state = SEL_B;
            end
            SEL_A: begin
                if (!a_valid)
                    next_state = b_valid ? SEL_B : IDLE;
                else if (xfer_a && (burst_cnt == BURST_LAST) && b_valid)
                    next_state = SEL_B;
            end
            SEL_B: begin
                if (!b_valid)
                    next_state = a_valid ? SEL_A : IDLE;
                else if (xfer_b && (burst_cnt == BURST_LAST) && a_valid)
                    next_state = SEL_A;
            end
            default: next_state = IDLE;
        endcase
        entering = (next_state != state) && (next_state != IDLE);
    end

    // A fresh grant restarts the burst count; s and last only move when a side is newly granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s         <= 1'b0;
            last      <= 1'b1;
            burst_cnt <= 8'd0;
        end else begin
            state <= next_state;
            if (entering) begin
                burst_cnt <= 8'd0;
                last      <= (next_state == SEL_B);
                s         <= (next_state == SEL_B);
            end else if (xfer && (burst_cnt != 8'hFF)) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if (xfer) begin
            y_valid <= 1'b1;
            y_data  <= s ? b_data : a_data;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt <= 16'd0;
            b_cnt <= 16'd0;
        end else begin
            if (xfer_a && (a_cnt != 16'hFFFF))
                a_cnt <= a_cnt + 16'd1;
            if (xfer_b && (b_cnt != 16'hFFFF))
                b_cnt <= b_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2to1_arb.sv
// Self-checking bench for mux_2to1_arb: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a grant/buffer reference model.
module tb_mux_2to1_arb;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready = 1'b0;
    logic             s;
`ifdef ARB_STATS_EN
    logic [15:0]      a_cnt;
    logic [15:0]      b_cnt;
`endif

    mux_2to1_arb #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready),
        .s       (s)
`ifdef ARB_STATS_EN
        ,
        .a_cnt   (a_cnt),
        .b_cnt   (b_cnt)
`endif
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;
    bit checkEn    = 1'b0;

    // Reference model: grant holder (0 none, 1 a, 2 b), last granted side, transfers in this grant.
    int         mGrant;
    int         mLast;
    int         mRun;
    bit         mYValid;
    logic [7:0] mYData;
    bit         mS;
    int         mACnt;
    int         mBCnt;
    bit         mXferA;
    bit         mXferB;

    task automatic modelReset();
        mGrant  = 0;
        mLast   = 2;
        mRun    = 0;
        mYValid = 1'b0;
        mYData  = 8'h00;
        mS      = 1'b0;
        mACnt   = 0;
        mBCnt   = 0;
        mXferA  = 1'b0;
        mXferB  = 1'b0;
    endtask

    task automatic modelStep();
        bit space;
        int newGrant;
        int runSat;
        if (rst) return;
        space  = !mYValid || y_ready;
        mXferA = (mGrant == 1) && a_valid && space;
        mXferB = (mGrant == 2) && b_valid && space;
        runSat = (mRun > 255) ? 255 : mRun;
        if (mXferA) begin
            mYData = a_data; mYValid = 1'b1;
            if (mACnt < 65535) mACnt++;
        end else if (mXferB) begin
            mYData = b_data; mYValid = 1'b1;
            if (mBCnt < 65535) mBCnt++;
        end else if (y_ready) begin
            mYValid = 1'b0;
        end
        newGrant = mGrant;
        if (mGrant == 0) begin
            if (a_valid && b_valid) newGrant = 3 - mLast;
            else if (a_valid)       newGrant = 1;
            else if (b_valid)       newGrant = 2;
        end else if (mGrant == 1) begin
            if (!a_valid) newGrant = b_valid ? 2 : 0;
            else if (mXferA && b_valid && runSat == MAX_BURST - 1) newGrant = 2;
        end else begin
            if (!b_valid) newGrant = a_valid ? 1 : 0;
            else if (mXferB && a_valid && runSat == MAX_BURST - 1) newGrant = 1;
        end
        if (newGrant != mGrant && newGrant != 0) begin
            mRun  = 0;
            mLast = newGrant;
            mS    = (newGrant == 2);
        end else if (mXferA || mXferB) begin
            mRun++;
        end
        mGrant = newGrant;
    endtask

    task automatic applyStimulus(input bit av, input logic [7:0] ad, input bit bv,
                                 input logic [7:0] bd, input bit yr);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        else
            passCount++;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        modelReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Every-cycle comparison against the model; readies use the live inputs.
    always @(negedge clk) begin
        if (checkEn) begin
            logic expA, expB;
            logic ok;
            expA = (mGrant == 1) && (!mYValid || y_ready);
            expB = (mGrant == 2) && (!mYValid || y_ready);
            ok = (a_ready === expA) && (b_ready === expB) && (y_valid === mYValid) &&
                 (y_data === mYData) && (s === mS);
`ifdef ARB_STATS_EN
            ok = ok && (a_cnt === 16'(mACnt)) && (b_cnt === 16'(mBCnt));
`endif
            checkCount++;
            if (!ok)
                $display("[TB] FAIL model_compare t=%0t: ar/br/yv/yd/s got %b/%b/%b/%h/%b expected %b/%b/%b/%h/%b",
                         $time, a_ready, b_ready, y_valid, y_data, s,
                         expA, expB, mYValid, mYData, mS);
            else
                passCount++;
        end
    end

    initial begin
        modelReset();
        checkEn = 1'b1;
        resetDut();

        // Idle after reset: everything stays at reset values.
        checkOutput("reset_y_data", 16'(y_data), 16'h0000);
        repeat (3) begin
            stepCycle();
            checkOutput("idle_y_valid", 16'(y_valid), 16'h0);
            checkOutput("idle_s", 16'(s), 16'h0);
            checkOutput("idle_readies", {14'h0, a_ready, b_ready}, 16'h0);
        end

        // Single requester a with 5A: ready on cycle 1, data out on cycle 2.
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        stepCycle();
        checkOutput("a_only_c1_a_ready", 16'(a_ready), 16'h1);
        checkOutput("a_only_c1_y_valid", 16'(y_valid), 16'h0);
        stepCycle();
        checkOutput("a_only_c2_y_valid", 16'(y_valid), 16'h1);
        checkOutput("a_only_c2_y_data", 16'(y_data), 16'h005A);
        checkOutput("a_only_c2_s", 16'(s), 16'h0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) stepCycle();

        // Both requesting continuously: AAAABBBBAAAA with no bubble.
        resetDut();
        applyStimulus(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1);
        stepCycle();
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            checkOutput("burst_y_valid", 16'(y_valid), 16'h1);
            checkOutput("burst_y_data", 16'(y_data), ((i / 4) % 2 == 0) ? 16'h00A1 : 16'h00B2);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) stepCycle();

        // Output stall for 3 cycles holds data and blocks a.
        resetDut();
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_a_ready", 16'(a_ready), 16'h0);
            checkOutput("stall_y_data", 16'(y_data), 16'h0011);
            stepCycle();
        end
        applyStimulus(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
        #1 checkOutput("resume_a_ready", 16'(a_ready), 16'h1);
        stepCycle();
        checkOutput("resume_y_data", 16'(y_data), 16'h0022);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) stepCycle();

        // a drops mid-burst while b waits: switch to b next cycle.
        resetDut();
        applyStimulus(1'b1, 8'h44, 1'b0, 8'h00, 1'b1);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
        stepCycle();
        checkOutput("drop_s", 16'(s), 16'h1);
        checkOutput("drop_b_ready", 16'(b_ready), 16'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) stepCycle();

        // Asynchronous reset while the buffer is full.
        resetDut();
        applyStimulus(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("pre_rst_y_valid", 16'(y_valid), 16'h1);
        #1 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst_y_valid", 16'(y_valid), 16'h0);
        checkOutput("async_rst_a_ready", 16'(a_ready), 16'h0);
        checkOutput("async_rst_s", 16'(s), 16'h0);
`ifdef ARB_STATS_EN
        checkOutput("async_rst_a_cnt", a_cnt, 16'h0000);
        checkOutput("async_rst_b_cnt", b_cnt, 16'h0000);
`endif
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic obeying the hold-until-transfer rule, with occasional withdrawals.
        for (int n = 0; n < 3000; n++) begin
            if (!a_valid || mXferA) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_data  = 8'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                a_valid = 1'b0;
            end
            if (!b_valid || mXferB) begin
                b_valid = ($urandom_range(0, 99) < 60);
                b_data  = 8'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                b_valid = 1'b0;
            end
            y_ready = ($urandom_range(0, 99) < 70);
            stepCycle();
        end

        @(negedge clk);
        #1 checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
